uart_packet_parser: RTL and testbench

Byte-to-packet framing stage directly downstream of the UART receiver. It consumes received bytes (`rx_data`/`rx_valid`) and the receiver's `frame_error` flag, hunts for a start-of-frame byte, and collects a command byte, a length byte, up to `MAX_PAYLOAD` payload bytes and an XOR checksum. It presents each validated packet on a valid/ready output port and reports framing, checksum, length, timeout and drop errors as one-cycle pulses.

---
 rtl/uart_packet_parser.sv | 160 ++++++++++++++++
 tb/tb_uart_packet_parser.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_parser.sv
// Framing stage behind the UART receiver: hunts SOF, collects CMD/LEN/payload/CHK,
// presents validated packets on a valid/ready port and pulses one-cycle error flags.
module uart_packet_parser #(
  parameter int         MAX_PAYLOAD    = 8,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_frame_error,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic [7:0]               pkt_cmd,
  output logic [7:0]               pkt_len,
  output logic [8*MAX_PAYLOAD-1:0] pkt_data,
  output logic                     err_frame,
  output logic                     err_chk,
  output logic                     err_len,
  output logic                     err_timeout,
  output logic                     err_drop
);

  localparam logic [7:0] MAXP = 8'(MAX_PAYLOAD);
  // Compare value chosen so the pulse lands TIMEOUT_CYCLES-1 cycles after the
  // last byte's strobe cycle (counter reads 0 the cycle after a byte).
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 3) ? TIMEOUT_CYCLES - 3 : 0;
  localparam int CW       = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHECK, S_HOLD
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic                          r_fe_q;
  logic [7:0]                    r_cmd, r_len, r_xor, r_idx;
  logic [MAX_PAYLOAD-1:0][7:0]   r_data;
  logic [CW-1:0]                 r_cnt;
  logic                          r_err_frame, r_err_chk, r_err_len, r_err_tmo, r_err_drop;
  logic                          w_fe_rise, w_recv, w_take, w_tmo_hit, w_sof;
  logic                          w_err_chk, w_err_len, w_err_tmo, w_err_drop;

  assign w_fe_rise = rx_frame_error & ~r_fe_q;
  assign w_recv    = (r_state == S_CMD) || (r_state == S_LEN) ||
                     (r_state == S_PAYLOAD) || (r_state == S_CHECK);
  assign w_take    = w_recv & rx_valid & ~w_fe_rise;
  assign w_tmo_hit = (r_cnt == CW'(TMO_LAST));
  assign w_sof     = (r_state == S_IDLE) && rx_valid && (rx_data == SOF_BYTE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_chk   = 1'b0;
    w_err_len   = 1'b0;
    w_err_tmo   = 1'b0;
    w_err_drop  = 1'b0;
    case (r_state)
      S_IDLE: if (w_sof) w_state_nxt = S_CMD;
      S_HOLD: begin
        w_err_drop = rx_valid;
        if (pkt_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        // abort beats a same-cycle byte; a byte beats the timeout
        if (w_fe_rise) w_state_nxt = S_IDLE;
        else if (rx_valid) begin
          case (r_state)
            S_CMD: w_state_nxt = S_LEN;
            S_LEN: begin
              if (rx_data > MAXP) begin
                w_err_len   = 1'b1;
                w_state_nxt = S_IDLE;
              end else if (rx_data == 8'd0) w_state_nxt = S_CHECK;
              else                          w_state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: if (r_idx + 8'd1 == r_len) w_state_nxt = S_CHECK;
            S_CHECK: begin
              if (rx_data == r_xor) w_state_nxt = S_HOLD;
              else begin
                w_err_chk   = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end else if (w_tmo_hit) begin
          w_err_tmo   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fe_q      <= 1'b0;
      r_cmd       <= '0;
      r_len       <= '0;
      r_xor       <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_err_frame <= 1'b0;
      r_err_chk   <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_err_drop  <= 1'b0;
    end else begin
      r_fe_q      <= rx_frame_error;
      r_err_frame <= w_fe_rise;
      r_err_chk   <= w_err_chk;
      r_err_len   <= w_err_len;
      r_err_tmo   <= w_err_tmo;
      r_err_drop  <= w_err_drop;
      r_cnt       <= (w_recv && !rx_valid && !w_tmo_hit) ? r_cnt + 1'b1 : '0;
      if (w_sof) begin
        r_data <= '0;
        r_xor  <= '0;
        r_idx  <= '0;
      end
      if (w_take) begin
        case (r_state)
          S_CMD: begin
            r_cmd <= rx_data;
            r_xor <= r_xor ^ rx_data;
          end
          S_LEN: begin
            if (rx_data <= MAXP) begin
              r_len <= rx_data;
              r_xor <= r_xor ^ rx_data;
            end
          end
          S_PAYLOAD: begin
            for (int i = 0; i < MAX_PAYLOAD; i++)
              if (r_idx == 8'(i)) r_data[i] <= rx_data;
            r_xor <= r_xor ^ rx_data;
            r_idx <= r_idx + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign pkt_valid   = (r_state == S_HOLD);
  assign pkt_cmd     = r_cmd;
  assign pkt_len     = r_len;
  assign pkt_data    = r_data;
  assign err_frame   = r_err_frame;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_tmo;
  assign err_drop    = r_err_drop;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Bench for uart_packet_parser: vector table, hand-written corner sequences and a
// randomized byte stream checked against a stream-level packet model.
module tb_uart_packet_parser;
  localparam int MP  = 8;
  localparam int TMO = 50;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0, rx_frame_error = 1'b0, pkt_ready = 1'b0;
  logic          pkt_valid;
  logic [7:0]    pkt_cmd, pkt_len;
  logic [8*MP-1:0] pkt_data;
  logic          err_frame, err_chk, err_len, err_timeout, err_drop;

  always #5 clk = ~clk;

  uart_packet_parser #(.MAX_PAYLOAD(MP), .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_error(rx_frame_error), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_cmd(pkt_cmd), .pkt_len(pkt_len), .pkt_data(pkt_data),
    .err_frame(err_frame), .err_chk(err_chk), .err_len(err_len),
    .err_timeout(err_timeout), .err_drop(err_drop));

  int n_chk = 0, n_err = 0;
  int m_frame = 0, m_chk = 0, m_len = 0, m_tmo = 0, m_drop = 0;
  logic [79:0] obs[$];

  // pulse counters and transfer capture, mid-cycle
  always @(negedge clk) begin
    if (err_frame)   m_frame++;
    if (err_chk)     m_chk++;
    if (err_len)     m_len++;
    if (err_timeout) m_tmo++;
    if (err_drop)    m_drop++;
    if (pkt_valid && pkt_ready) obs.push_back({pkt_cmd, pkt_len, pkt_data});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [95:0] s;
    int          n;
    logic        v;
    logic [7:0]  cmd, len;
    logic [63:0] data;
    int          echk, elen;
  } vec_t;
  vec_t tv[8];

  function automatic logic [7:0] vbyte(input logic [95:0] s, input int n, input int j);
    return s[8*(n-1-j) +: 8];
  endfunction

  // stream-level model: scan the whole byte list for frames
  logic [7:0]  st[$];
  logic [79:0] expq[$];
  int          e_chk, e_len;

  function automatic void model_parse();
    int i, n, l;
    logic [7:0]  c, x;
    logic [63:0] d;
    i = 0; n = st.size();
    expq.delete(); e_chk = 0; e_len = 0;
    while (i < n) begin
      if (st[i] != 8'hA5) begin i++; continue; end
      if (i + 2 >= n) break;
      c = st[i+1]; l = int'(st[i+2]);
      if (l > MP) begin e_len++; i += 3; continue; end
      if (i + 3 + l >= n) break;
      x = c ^ 8'(l); d = '0;
      for (int k = 0; k < l; k++) begin
        x = x ^ st[i+3+k];
        d[8*k +: 8] = st[i+3+k];
      end
      if (st[i+3+l] == x) expq.push_back({c, 8'(l), d});
      else                e_chk++;
      i += 4 + l;
    end
  endfunction

  initial begin
    int b_frame, b_chk, b_len, b_tmo, b_drop, first, ob;
    logic [7:0] c, x;
    int l, kind;

    tv[0] = '{s:96'hA5_10_02_33_44_65, n:6, v:1'b1, cmd:8'h10, len:8'h02, data:64'h4433, echk:0, elen:0};
    tv[1] = '{s:96'hA5_07_00_07, n:4, v:1'b1, cmd:8'h07, len:8'h00, data:64'h0, echk:0, elen:0};
    tv[2] = '{s:96'hA5_10_01_FF_00, n:5, v:1'b0, cmd:8'h0, len:8'h0, data:64'h0, echk:1, elen:0};
    tv[3] = '{s:96'hA5_01_00_01, n:4, v:1'b1, cmd:8'h01, len:8'h00, data:64'h0, echk:0, elen:0};
    tv[4] = '{s:96'hA5_01_09, n:3, v:1'b0, cmd:8'h0, len:8'h0, data:64'h0, echk:0, elen:1};
    tv[5] = '{s:96'h09_00_09_09, n:4, v:1'b0, cmd:8'h0, len:8'h0, data:64'h0, echk:0, elen:0};
    tv[6] = '{s:96'hA5_22_08_01_02_03_04_05_06_07_08_22, n:12, v:1'b1, cmd:8'h22, len:8'h08,
              data:64'h0807060504030201, echk:0, elen:0};
    tv[7] = '{s:96'h00_FF_5A_A5_33_01_C3_F1, n:8, v:1'b1, cmd:8'h33, len:8'h01, data:64'hC3, echk:0, elen:0};

    // reset state
    step(); step();
    chk("rst_valid", 64'(pkt_valid), 64'h0);
    chk("rst_cmd_len", {48'h0, pkt_cmd, pkt_len}, 64'h0);
    chk("rst_data", pkt_data, 64'h0);
    chk("rst_err", {59'h0, err_frame, err_chk, err_len, err_timeout, err_drop}, 64'h0);
    reset_n = 1'b1;
    step();

    // vector table, consumer always ready
    pkt_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      b_chk = m_chk; b_len = m_len; b_frame = m_frame + m_tmo + m_drop;
      for (int j = 0; j < tv[t].n; j++) send(vbyte(tv[t].s, tv[t].n, j));
      chk($sformatf("tv%0d_valid", t), 64'(pkt_valid), 64'(tv[t].v));
      if (tv[t].v) begin
        chk($sformatf("tv%0d_cmd", t), 64'(pkt_cmd), 64'(tv[t].cmd));
        chk($sformatf("tv%0d_len", t), 64'(pkt_len), 64'(tv[t].len));
        chk($sformatf("tv%0d_data", t), pkt_data, tv[t].data);
      end
      idle(3);
      chk($sformatf("tv%0d_valid_after", t), 64'(pkt_valid), 64'h0);
      chki($sformatf("tv%0d_err_chk", t), m_chk - b_chk, tv[t].echk);
      chki($sformatf("tv%0d_err_len", t), m_len - b_len, tv[t].elen);
      chki($sformatf("tv%0d_err_other", t), m_frame + m_tmo + m_drop - b_frame, 0);
    end

    // back-pressure, drop in HOLD, SOF in the transfer cycle
    pkt_ready = 1'b0;
    b_drop = m_drop;
    send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
    idle(20);
    chk("bp_valid", 64'(pkt_valid), 64'h1);
    chk("bp_cmd_len", {48'h0, pkt_cmd, pkt_len}, 64'h0700);
    send(8'hA5);
    idle(1);
    chki("bp_drop1", m_drop - b_drop, 1);
    chk("bp_hold_stable", {47'h0, pkt_valid, pkt_cmd, pkt_len}, 64'h1_0700);
    rx_data = 8'hA5; rx_valid = 1'b1; pkt_ready = 1'b1;
    step();
    rx_valid = 1'b0;
    chk("bp_valid_after_xfer", 64'(pkt_valid), 64'h0);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
    chk("bp_next_pkt", {47'h0, pkt_valid, pkt_cmd, pkt_len}, 64'h1_0100);
    idle(2);
    chki("bp_drop2", m_drop - b_drop, 2);

    // timeout lands TMO-1 cycles after the last strobe
    b_tmo = m_tmo;
    send(8'hA5); send(8'h10);
    first = -1;
    for (int k = 1; k <= 60; k++) begin
      if (err_timeout && first < 0) first = k;
      step();
    end
    chki("tmo_cycle", first, TMO - 1);
    chki("tmo_count", m_tmo - b_tmo, 1);
    b_tmo = m_tmo;
    send(8'hA5); send(8'h10);
    idle(47);
    send(8'h00);
    idle(10);
    send(8'h10);
    chk("tmo_rescued_pkt", {47'h0, pkt_valid, pkt_cmd, pkt_len}, 64'h1_1000);
    idle(2);
    chki("tmo_rescued_none", m_tmo - b_tmo, 0);

    // frame error during payload, held two cycles, with a byte on the edge
    b_frame = m_frame; b_chk = m_chk + m_len + m_tmo + m_drop;
    send(8'hA5); send(8'h10); send(8'h03); send(8'h11);
    rx_frame_error = 1'b1; rx_data = 8'h22; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    rx_frame_error = 1'b0;
    step();
    send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    chk("fe_no_pkt", 64'(pkt_valid), 64'h0);
    idle(2);
    chki("fe_one_pulse", m_frame - b_frame, 1);
    chki("fe_no_other_err", m_chk + m_len + m_tmo + m_drop - b_chk, 0);
    rx_frame_error = 1'b1; step(); rx_frame_error = 1'b0; idle(2);
    chki("fe_idle_pulse", m_frame - b_frame, 2);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
    chk("fe_recover_pkt", {47'h0, pkt_valid, pkt_cmd, pkt_len}, 64'h1_0100);
    idle(2);

    // asynchronous reset while holding a packet
    pkt_ready = 1'b0;
    send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
    chk("ar_pre_data", pkt_data, 64'h4433);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(pkt_valid), 64'h0);
    chk("ar_cmd_len", {48'h0, pkt_cmd, pkt_len}, 64'h0);
    chk("ar_data", pkt_data, 64'h0);
    chk("ar_err", {59'h0, err_frame, err_chk, err_len, err_timeout, err_drop}, 64'h0);
    #2 reset_n = 1'b1;
    pkt_ready = 1'b1;
    idle(2);

    // randomized stream against the model
    st.delete();
    for (int it = 0; it < 40; it++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        c = 8'($urandom_range(0, 255));
        st.push_back((c == 8'hA5) ? 8'h00 : c);
      end
      kind = int'($urandom_range(0, 3));
      c = 8'($urandom_range(0, 255));
      if (kind == 3) begin
        st.push_back(8'hA5); st.push_back(c); st.push_back(8'($urandom_range(MP + 1, 255)));
      end else begin
        l = int'($urandom_range(0, MP));
        st.push_back(8'hA5); st.push_back(c); st.push_back(8'(l));
        x = c ^ 8'(l);
        for (int k = 0; k < l; k++) begin
          st.push_back(8'($urandom_range(0, 255)));
          x = x ^ st[st.size()-1];
        end
        if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
        st.push_back(x);
      end
    end
    model_parse();
    b_chk = m_chk; b_len = m_len; b_frame = m_frame + m_tmo + m_drop; ob = obs.size();
    foreach (st[i]) begin
      send(st[i]);
      idle(int'($urandom_range(1, 3)));
    end
    idle(5);
    chki("rnd_pkt_count", obs.size() - ob, expq.size());
    for (int i = 0; i < expq.size() && ob + i < obs.size(); i++)
      chk($sformatf("rnd_pkt%0d", i), obs[ob+i][63:0] ^ {48'h0, obs[ob+i][79:64]} ^ 64'(i),
          expq[i][63:0] ^ {48'h0, expq[i][79:64]} ^ 64'(i));
    for (int i = 0; i < expq.size() && ob + i < obs.size(); i++)
      chk($sformatf("rnd_hdr%0d", i), 64'(obs[ob+i][79:64]), 64'(expq[i][79:64]));
    chki("rnd_err_chk", m_chk - b_chk, e_chk);
    chki("rnd_err_len", m_len - b_len, e_len);
    chki("rnd_err_other", m_frame + m_tmo + m_drop - b_frame, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
